// File: rtl/image_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : image_uart_tx
// Purpose  : Output stage for processed image pixels. Bytes arrive over a
//            valid/ready handshake, are buffered in a circular FIFO and sent
//            on a UART line (8N1, LSB first). A one-cycle frame_done pulse
//            marks the end of every FRAME_PIXELS-byte frame on the line.
// Ports    : clk         system clock, rising edge
//            rst         asynchronous reset, active high
//            pix_data    pixel byte from the core
//            pix_valid   pix_data valid this cycle
//            pix_ready   FIFO can take a byte this cycle (combinational)
//            tx          UART serial line, idle high (registered)
//            fifo_count  bytes currently buffered (registered)
//            frame_done  one-cycle pulse when a frame's last stop bit ends
// Revision : 1.0  initial release
// ============================================================================
module image_uart_tx #(
  parameter int CLK_DIV      = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int FRAME_PIXELS = 65536
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    pix_data,
  input  logic                          pix_valid,
  output logic                          pix_ready,
  output logic                          tx,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          frame_done
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int BW = $clog2(CLK_DIV);
  localparam int FW = (FRAME_PIXELS > 1) ? $clog2(FRAME_PIXELS) : 1;

  localparam logic [BW-1:0] BAUD_LAST  = BW'(CLK_DIV - 1);
  localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_PIXELS - 1);
  localparam logic [CW-1:0] FIFO_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // --------------------------------------------------------------------------
  // Pixel FIFO
  // --------------------------------------------------------------------------
  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  logic [7:0]    head;

  // Readiness looks only at the registered count, so a pop in the same cycle
  // never makes room for a write: a full FIFO always refuses.
  assign pix_ready = !rst && (fifo_count < FIFO_FULL);
  assign push      = pix_valid && pix_ready;
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= pix_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      // Pointers are PW bits wide, so they wrap at FIFO_DEPTH on their own.
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // UART transmitter FSM
  // --------------------------------------------------------------------------
  state_t        state, state_n;
  logic [BW-1:0] baud, baud_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shift, shift_n;
  logic [FW-1:0] frame_cnt, frame_cnt_n;
  logic          tx_n;
  logic          frame_done_n;
  logic          baud_end;

  assign baud_end = (baud == BAUD_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      baud       <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      frame_cnt  <= '0;
      tx         <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_n;
      baud       <= baud_n;
      bit_idx    <= bit_idx_n;
      shift      <= shift_n;
      frame_cnt  <= frame_cnt_n;
      tx         <= tx_n;
      frame_done <= frame_done_n;
    end
  end

  always_comb begin
    state_n      = state;
    baud_n       = baud;
    bit_idx_n    = bit_idx;
    shift_n      = shift;
    frame_cnt_n  = frame_cnt;
    tx_n         = tx;
    frame_done_n = 1'b0;
    pop          = 1'b0;

    case (state)
      IDLE: begin
        tx_n   = 1'b1;
        baud_n = '0;
        if (fifo_count != '0) begin
          pop     = 1'b1;
          shift_n = head;
          tx_n    = 1'b0;
          state_n = START;
        end
      end

      START: begin
        if (baud_end) begin
          baud_n    = '0;
          bit_idx_n = 3'd0;
          tx_n      = shift[0];
          state_n   = DATA;
        end else begin
          baud_n = baud + BW'(1);
        end
      end

      DATA: begin
        if (baud_end) begin
          baud_n = '0;
          if (bit_idx == 3'd7) begin
            tx_n    = 1'b1;
            state_n = STOP;
          end else begin
            // The next bit to drive is shift[1], i.e. bit 0 after the shift.
            shift_n   = {1'b0, shift[7:1]};
            tx_n      = shift[1];
            bit_idx_n = bit_idx + 3'd1;
          end
        end else begin
          baud_n = baud + BW'(1);
        end
      end

      STOP: begin
        if (baud_end) begin
          baud_n = '0;
          if (frame_cnt == FRAME_LAST) begin
            frame_done_n = 1'b1;
            frame_cnt_n  = '0;
          end else begin
            frame_cnt_n = frame_cnt + FW'(1);
          end
          // Chain straight into the next start bit when data is waiting.
          if (fifo_count != '0) begin
            pop     = 1'b1;
            shift_n = head;
            tx_n    = 1'b0;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud + BW'(1);
        end
      end

      default: begin
        tx_n    = 1'b1;
        baud_n  = '0;
        state_n = IDLE;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_image_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_image_uart_tx
// Purpose  : Directed self-checking bench for image_uart_tx with CLK_DIV=4,
//            FIFO_DEPTH=4, FRAME_PIXELS=3. Expected line waveforms are built
//            from the stimulus bytes as {stop, data, start} frames.
// Revision : 1.0  initial release
// ============================================================================
module tb_image_uart_tx;

  localparam int CLK_DIV      = 4;
  localparam int FIFO_DEPTH   = 4;
  localparam int FRAME_PIXELS = 3;
  localparam int BIT_CYC      = CLK_DIV;
  localparam int BYTE_CYC     = 10 * CLK_DIV;
  localparam int LOG_LEN      = 512;

  logic       clk;
  logic       rst;
  logic [7:0] pix_data;
  logic       pix_valid;
  logic       pix_ready;
  logic       tx;
  logic [2:0] fifo_count;
  logic       frame_done;

  int n_pass;
  int n_total;
  int last_pulses;

  logic [7:0] stim      [8];
  logic [2:0] count_log [LOG_LEN];
  logic       ready_log [LOG_LEN];

  image_uart_tx #(
    .CLK_DIV      (CLK_DIV),
    .FIFO_DEPTH   (FIFO_DEPTH),
    .FRAME_PIXELS (FRAME_PIXELS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pix_data   (pix_data),
    .pix_valid  (pix_valid),
    .pix_ready  (pix_ready),
    .tx         (tx),
    .fifo_count (fifo_count),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  // Leaves the bench at a negedge with reset released and settled.
  task automatic do_reset();
    @(negedge clk);
    pix_valid = 1'b0;
    pix_data  = 'x;
    rst       = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Offers stim[0..n-1] with pix_valid held high until each byte is taken,
  // and compares the line, frame_done and readiness every cycle. Sample s=0
  // is the first cycle of the first start bit (two negedges after the take).
  task automatic run_stream(input int n);
    int         c;
    int         first_c;
    int         sent;
    int         s;
    int         pulses;
    bit         finished;
    logic       exp_done;
    logic [9:0] fr;
    c        = 0;
    first_c  = -1;
    sent     = 0;
    pulses   = 0;
    finished = 1'b0;
    while (!finished && c < LOG_LEN) begin
      count_log[c] = fifo_count;
      ready_log[c] = pix_ready;
      check("ready_vs_count", {31'd0, pix_ready}, {31'd0, (fifo_count < 3'd4)});
      if (sent < n) begin
        pix_data  = stim[sent];
        pix_valid = 1'b1;
      end else begin
        pix_data  = 'x;
        pix_valid = 1'b0;
      end
      if (first_c < 0 || c < first_c + 2) begin
        check("tx_before_start", {31'd0, tx}, 32'd1);
        check("done_before_start", {31'd0, frame_done}, 32'd0);
      end else begin
        s = c - first_c - 2;
        if (s < n * BYTE_CYC) begin
          fr = {1'b1, stim[s / BYTE_CYC], 1'b0};
          check("tx_bit", {31'd0, tx}, {31'd0, fr[(s % BYTE_CYC) / BIT_CYC]});
        end else begin
          check("tx_idle_after", {31'd0, tx}, 32'd1);
          finished = 1'b1;
        end
        exp_done = (s > 0) && (s % BYTE_CYC == 0) && ((s / BYTE_CYC) % FRAME_PIXELS == 0);
        check("frame_done", {31'd0, frame_done}, {31'd0, exp_done});
        if (frame_done) pulses++;
      end
      if (pix_valid && pix_ready) begin
        if (first_c < 0) first_c = c;
        sent++;
      end
      @(negedge clk);
      c++;
    end
    check("stream_complete", {31'd0, finished}, 32'd1);
    pix_valid   = 1'b0;
    pix_data    = 'x;
    last_pulses = pulses;
  endtask

  initial begin
    n_pass      = 0;
    n_total     = 0;
    last_pulses = 0;
    rst         = 1'b1;
    pix_valid   = 1'b0;
    pix_data    = 'x;

    // Reset state while rst is high.
    #1;
    check("rst_tx", {31'd0, tx}, 32'd1);
    check("rst_count", {29'd0, fifo_count}, 32'd0);
    check("rst_ready", {31'd0, pix_ready}, 32'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rel_ready", {31'd0, pix_ready}, 32'd1);

    // Reset mid-byte: 0xC3 on the line, 0x5A buffered.
    pix_data  = 8'hC3;
    pix_valid = 1'b1;
    @(negedge clk);
    pix_data  = 8'h5A;
    @(negedge clk);
    pix_valid = 1'b0;
    pix_data  = 'x;
    repeat (3) @(negedge clk);
    check("mid_tx_start", {31'd0, tx}, 32'd0);
    check("mid_count", {29'd0, fifo_count}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_tx", {31'd0, tx}, 32'd1);
    check("async_rst_count", {29'd0, fifo_count}, 32'd0);
    check("async_rst_ready", {31'd0, pix_ready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", {31'd0, pix_ready}, 32'd1);
    for (int i = 0; i < 50; i++) begin
      check("post_rst_idle_tx", {31'd0, tx}, 32'd1);
      check("post_rst_count", {29'd0, fifo_count}, 32'd0);
      @(negedge clk);
    end

    // Single byte 0xA5.
    do_reset();
    stim[0] = 8'hA5;
    run_stream(1);

    // Back-to-back 0x00, 0xFF.
    do_reset();
    stim[0] = 8'h00;
    stim[1] = 8'hFF;
    run_stream(2);

    // Burst of 6 with valid held high; checks full-FIFO behaviour too.
    do_reset();
    stim[0] = 8'h11; stim[1] = 8'h22; stim[2] = 8'h33;
    stim[3] = 8'h44; stim[4] = 8'h55; stim[5] = 8'h66;
    run_stream(6);
    check("burst_cnt_c4", {29'd0, count_log[4]}, 32'd3);
    check("burst_rdy_c4", {31'd0, ready_log[4]}, 32'd1);
    check("burst_cnt_c5", {29'd0, count_log[5]}, 32'd4);
    check("burst_rdy_c5", {31'd0, ready_log[5]}, 32'd0);
    // First pop from a full FIFO refuses the same-cycle write.
    check("full_pop_cnt_c41", {29'd0, count_log[41]}, 32'd4);
    check("full_pop_rdy_c41", {31'd0, ready_log[41]}, 32'd0);
    check("full_pop_cnt_c42", {29'd0, count_log[42]}, 32'd3);
    check("full_pop_rdy_c42", {31'd0, ready_log[42]}, 32'd1);
    check("full_pop_cnt_c43", {29'd0, count_log[43]}, 32'd4);

    // Seven bytes: two frame_done pulses, after bytes 3 and 6.
    do_reset();
    stim[0] = 8'h01; stim[1] = 8'h80; stim[2] = 8'h3C; stim[3] = 8'hE7;
    stim[4] = 8'h5A; stim[5] = 8'hC3; stim[6] = 8'h96;
    run_stream(7);
    check("frame_pulses", last_pulses, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
